// File: rtl/cnn_stream_loader_if.sv
// rtl/cnn_stream_loader_if.sv - stream and bus bundle between upstream feeder, loader and accelerator
//
// Groups the two 32-bit valid/ready/last payload streams (data image, filter), the
// accelerator memory write bus (addrOut/wrEnOut/wrDataOut) and the accelerator control
// and status signals (dimensions, startOut, doneIn, errorOut).
//   slave  : the loader side (consumes streams, drives bus/dims/start/error)
//   master : the environment side (drives streams and doneIn, observes the rest)
interface cnn_stream_loader_if #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int DIM_WIDTH      = 13
);
    logic [DATA_WIDTH-1:0]       dataIn;
    logic                        dataValidIn;
    logic                        dataLastIn;
    logic                        dataReadyOut;
    logic [DATA_WIDTH-1:0]       filtIn;
    logic                        filtValidIn;
    logic                        filtLastIn;
    logic                        filtReadyOut;
    logic                        doneIn;
    logic [BUS_ADDR_WIDTH-1:0]   addrOut;
    logic [BUS_DATA_WIDTH/8-1:0] wrEnOut;
    logic [BUS_DATA_WIDTH-1:0]   wrDataOut;
    logic [DIM_WIDTH-1:0]        dataColsOut;
    logic [DIM_WIDTH-1:0]        dataRowsOut;
    logic [DIM_WIDTH-1:0]        filtColsOut;
    logic [DIM_WIDTH-1:0]        filtRowsOut;
    logic                        startOut;
    logic                        errorOut;

    modport slave (
        input  dataIn, dataValidIn, dataLastIn,
        output dataReadyOut,
        input  filtIn, filtValidIn, filtLastIn,
        output filtReadyOut,
        input  doneIn,
        output addrOut, wrEnOut, wrDataOut,
        output dataColsOut, dataRowsOut, filtColsOut, filtRowsOut,
        output startOut, errorOut
    );

    modport master (
        output dataIn, dataValidIn, dataLastIn,
        input  dataReadyOut,
        output filtIn, filtValidIn, filtLastIn,
        input  filtReadyOut,
        output doneIn,
        input  addrOut, wrEnOut, wrDataOut,
        input  dataColsOut, dataRowsOut, filtColsOut, filtRowsOut,
        input  startOut, errorOut
    );
endinterface

// File: rtl/cnn_stream_loader.sv
// rtl/cnn_stream_loader.sv - header/payload stream loader feeding cnn_hw_accelerator memory
//
// Accepts a data-image stream then a filter stream, each framed as: cols word, rows word,
// rows*cols payload words (last on the final one). Payload words are packed NUM_WORDS per
// bus beat (lane 0 in the LSBs) and written to the data region (from address 0) or the
// filter region (from FILT_BASE_ADDR). After the final filter beat a one-cycle startOut is
// issued and both streams are held off until doneIn.
// Ports:
//   clkIn   clock
//   rstNIn  asynchronous active-low reset
//   bus     cnn_stream_loader_if.slave: dataIn/dataValidIn/dataLastIn/dataReadyOut,
//           filtIn/filtValidIn/filtLastIn/filtReadyOut, doneIn, addrOut/wrEnOut/wrDataOut,
//           dataColsOut/dataRowsOut/filtColsOut/filtRowsOut, startOut, errorOut
module cnn_stream_loader #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_SIZE       = 4096,
    parameter int FILT_BASE_ADDR = 2048
) (
    input  logic              clkIn,
    input  logic              rstNIn,
    cnn_stream_loader_if.slave bus
);
    localparam int NUM_WORDS      = BUS_DATA_WIDTH / DATA_WIDTH;
    localparam int DIM_WIDTH      = $clog2(MAX_SIZE) + 1;
    localparam int LANE_WIDTH     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BYTES_PER_LANE = DATA_WIDTH / 8;
    localparam int WREN_WIDTH     = BUS_DATA_WIDTH / 8;
    localparam int CNT_WIDTH      = 2 * DIM_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_DCOLS, S_DROWS, S_DLOAD, S_DDRAIN,
        S_FCOLS, S_FROWS, S_FLOAD, S_FDRAIN, S_START, S_WAIT
    } state_t;

    state_t state, nextState;

    logic                      dataReadyQ, filtReadyQ, startQ, errorQ;
    logic [BUS_ADDR_WIDTH-1:0] addrQ, wrAddrQ;
    logic [WREN_WIDTH-1:0]     wrEnQ;
    logic [BUS_DATA_WIDTH-1:0] wrDataQ, packQ;
    logic [DIM_WIDTH-1:0]      dataColsQ, dataRowsQ, filtColsQ, filtRowsQ;
    logic [LANE_WIDTH-1:0]     laneQ;
    logic [CNT_WIDTH-1:0]      cntQ, expectedQ;
    logic                      colsBigQ;

    logic                      dataReadyD, filtReadyD, startD, errorD;
    logic [BUS_ADDR_WIDTH-1:0] addrD, wrAddrD;
    logic [WREN_WIDTH-1:0]     wrEnD;
    logic [BUS_DATA_WIDTH-1:0] wrDataD, packD, packNext;
    logic [DIM_WIDTH-1:0]      dataColsD, dataRowsD, filtColsD, filtRowsD;
    logic [LANE_WIDTH-1:0]     laneD;
    logic [CNT_WIDTH-1:0]      cntD, expectedD;
    logic                      colsBigD;

    logic                      inFilt, xfer, wordLast, wordBig, dimErr, loadErr, laneFull, frameErr;
    logic [DATA_WIDTH-1:0]     word;
    logic [DIM_WIDTH-1:0]      colsCur;
    logic [CNT_WIDTH-1:0]      product;
    logic [WREN_WIDTH-1:0]     laneMask;

    // Both streams share one parser; the state decides which stream is live.
    always_comb begin
        inFilt   = state inside {S_FCOLS, S_FROWS, S_FLOAD, S_FDRAIN};
        word     = inFilt ? bus.filtIn : bus.dataIn;
        wordLast = inFilt ? bus.filtLastIn : bus.dataLastIn;
        xfer     = inFilt ? (bus.filtValidIn & filtReadyQ) : (bus.dataValidIn & dataReadyQ);
        colsCur  = inFilt ? filtColsQ : dataColsQ;
        // Oversize checks use the full word so a truncated dimension cannot alias to a legal one.
        wordBig  = word > DATA_WIDTH'(MAX_SIZE);
        product  = CNT_WIDTH'(colsCur) * CNT_WIDTH'(word[DIM_WIDTH-1:0]);
        dimErr   = colsBigQ || wordBig || (colsCur == '0) || (word == '0) ||
                   (product > CNT_WIDTH'(MAX_SIZE));
        loadErr  = (cntQ == expectedQ) || (wordLast && ((cntQ + CNT_WIDTH'(1)) != expectedQ));
        laneFull = laneQ == LANE_WIDTH'(NUM_WORDS - 1);
        laneMask = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i <= int'(laneQ)) laneMask[i*BYTES_PER_LANE +: BYTES_PER_LANE] = '1;
        end
        packNext = packQ;
        packNext[laneQ*DATA_WIDTH +: DATA_WIDTH] = word;
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) state <= S_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        frameErr  = 1'b0;
        case (state)
            S_IDLE: if (bus.dataValidIn) nextState = S_DCOLS;
            S_DCOLS, S_FCOLS: if (xfer) begin
                if (wordLast) begin
                    nextState = S_IDLE;
                    frameErr  = 1'b1;
                end else begin
                    nextState = inFilt ? S_FROWS : S_DROWS;
                end
            end
            S_DROWS, S_FROWS: if (xfer) begin
                if (wordLast) begin
                    nextState = S_IDLE;
                    frameErr  = 1'b1;
                end else if (dimErr) begin
                    nextState = inFilt ? S_FDRAIN : S_DDRAIN;
                    frameErr  = 1'b1;
                end else begin
                    nextState = inFilt ? S_FLOAD : S_DLOAD;
                end
            end
            S_DLOAD, S_FLOAD: if (xfer) begin
                if (loadErr) begin
                    frameErr  = 1'b1;
                    nextState = wordLast ? S_IDLE : (inFilt ? S_FDRAIN : S_DDRAIN);
                end else if (wordLast) begin
                    nextState = inFilt ? S_START : S_FCOLS;
                end
            end
            S_DDRAIN, S_FDRAIN: if (xfer && wordLast) nextState = S_IDLE;
            S_START: nextState = S_WAIT;
            S_WAIT:  if (bus.doneIn) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        // Readies follow the upcoming state so they line up with the state register.
        dataReadyD = nextState inside {S_DCOLS, S_DROWS, S_DLOAD, S_DDRAIN};
        filtReadyD = nextState inside {S_FCOLS, S_FROWS, S_FLOAD, S_FDRAIN};
        startD     = (state == S_START);
        errorD     = errorQ | frameErr;
        dataColsD  = dataColsQ;
        dataRowsD  = dataRowsQ;
        filtColsD  = filtColsQ;
        filtRowsD  = filtRowsQ;
        colsBigD   = colsBigQ;
        expectedD  = expectedQ;
        cntD       = cntQ;
        laneD      = laneQ;
        packD      = packQ;
        wrAddrD    = wrAddrQ;
        addrD      = addrQ;
        wrEnD      = '0;
        wrDataD    = '0;

        if (xfer) begin
            case (state)
                S_DCOLS: begin dataColsD = word[DIM_WIDTH-1:0]; colsBigD = wordBig; end
                S_FCOLS: begin filtColsD = word[DIM_WIDTH-1:0]; colsBigD = wordBig; end
                S_DROWS: dataRowsD = word[DIM_WIDTH-1:0];
                S_FROWS: filtRowsD = word[DIM_WIDTH-1:0];
                default: ;
            endcase
        end

        if (xfer && (state == S_DROWS || state == S_FROWS)) begin
            expectedD = product;
            cntD      = '0;
            laneD     = '0;
            packD     = '0;
            wrAddrD   = inFilt ? BUS_ADDR_WIDTH'(FILT_BASE_ADDR) : '0;
        end

        if (xfer && (state == S_DLOAD || state == S_FLOAD) && !loadErr) begin
            cntD = cntQ + CNT_WIDTH'(1);
            if (laneFull || wordLast) begin
                wrEnD   = laneMask;
                wrDataD = packNext;
                addrD   = wrAddrQ;
                wrAddrD = wrAddrQ + BUS_ADDR_WIDTH'(1);
                laneD   = '0;
                packD   = '0;
            end else begin
                laneD = laneQ + LANE_WIDTH'(1);
                packD = packNext;
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            dataReadyQ <= 1'b0;
            filtReadyQ <= 1'b0;
            startQ     <= 1'b0;
            errorQ     <= 1'b0;
            addrQ      <= '0;
            wrAddrQ    <= '0;
            wrEnQ      <= '0;
            wrDataQ    <= '0;
            packQ      <= '0;
            dataColsQ  <= '0;
            dataRowsQ  <= '0;
            filtColsQ  <= '0;
            filtRowsQ  <= '0;
            laneQ      <= '0;
            cntQ       <= '0;
            expectedQ  <= '0;
            colsBigQ   <= 1'b0;
        end else begin
            dataReadyQ <= dataReadyD;
            filtReadyQ <= filtReadyD;
            startQ     <= startD;
            errorQ     <= errorD;
            addrQ      <= addrD;
            wrAddrQ    <= wrAddrD;
            wrEnQ      <= wrEnD;
            wrDataQ    <= wrDataD;
            packQ      <= packD;
            dataColsQ  <= dataColsD;
            dataRowsQ  <= dataRowsD;
            filtColsQ  <= filtColsD;
            filtRowsQ  <= filtRowsD;
            laneQ      <= laneD;
            cntQ       <= cntD;
            expectedQ  <= expectedD;
            colsBigQ   <= colsBigD;
        end
    end

    assign bus.dataReadyOut = dataReadyQ;
    assign bus.filtReadyOut = filtReadyQ;
    assign bus.startOut     = startQ;
    assign bus.errorOut     = errorQ;
    assign bus.addrOut      = addrQ;
    assign bus.wrEnOut      = wrEnQ;
    assign bus.wrDataOut    = wrDataQ;
    assign bus.dataColsOut  = dataColsQ;
    assign bus.dataRowsOut  = dataRowsQ;
    assign bus.filtColsOut  = filtColsQ;
    assign bus.filtRowsOut  = filtRowsQ;
endmodule

// File: tb/tb_cnn_stream_loader.sv
// tb/tb_cnn_stream_loader.sv - self-checking bench for cnn_stream_loader
module tb_cnn_stream_loader;
    logic clkIn = 1'b0;
    logic rstNIn = 1'b0;

    cnn_stream_loader_if bus ();
    cnn_stream_loader dut (.clkIn(clkIn), .rstNIn(rstNIn), .bus(bus));

    always #5 clkIn = ~clkIn;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  en;
        logic [63:0] data;
    } wr_t;

    wr_t         gotQ[$];
    int          gotCyc[$];
    wr_t         expQ[$];
    logic [31:0] dataWords[$];
    logic [31:0] filtWords[$];
    int cyc = 0;
    int startCnt = 0;
    int startCyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clkIn) cyc <= cyc + 1;

    always @(negedge clkIn) begin
        if (rstNIn && bus.wrEnOut != 8'h00) begin
            gotQ.push_back(wr_t'({bus.addrOut, bus.wrEnOut, bus.wrDataOut}));
            gotCyc.push_back(cyc);
        end
        if (rstNIn && bus.startOut) begin
            startCnt++;
            startCyc = cyc;
        end
    end

    task automatic clear_mon();
        gotQ.delete();
        gotCyc.delete();
        expQ.delete();
        startCnt = 0;
    endtask

    // Expected bus writes: consecutive word pairs form a beat, lower word in the low lane;
    // an odd trailing word makes a half beat with only the low byte enables.
    function automatic void model_stream(input logic [31:0] base, input bit isFilt);
        int n;
        n = isFilt ? filtWords.size() : dataWords.size();
        for (int k = 0; k < n; k += 2) begin
            wr_t w;
            logic [31:0] lo, hi;
            lo = isFilt ? filtWords[k] : dataWords[k];
            w.addr = base + 32'(k / 2);
            if (k + 1 < n) begin
                hi = isFilt ? filtWords[k+1] : dataWords[k+1];
                w.en = 8'hFF;
            end else begin
                hi = 32'h0;
                w.en = 8'h0F;
            end
            w.data = {hi, lo};
            expQ.push_back(w);
        end
    endfunction

    task automatic stop_streams();
        bus.dataValidIn = 1'b0;
        bus.dataLastIn  = 1'b0;
        bus.filtValidIn = 1'b0;
        bus.filtLastIn  = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the word was taken.
    task automatic drive_word(input bit isFilt, input logic [31:0] w, input bit last, input int gapMax);
        int gap;
        bit ok;
        gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        if (gap > 0) begin
            stop_streams();
            repeat (gap) @(negedge clkIn);
        end
        if (isFilt) begin
            bus.filtIn = w; bus.filtLastIn = last; bus.filtValidIn = 1'b1;
        end else begin
            bus.dataIn = w; bus.dataLastIn = last; bus.dataValidIn = 1'b1;
        end
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = isFilt ? bus.filtReadyOut : bus.dataReadyOut;
            @(negedge clkIn);
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL drive_word timeout: word %h on %s stream never accepted", w, isFilt ? "filt" : "data");
        end
    endtask

    task automatic send_stream(input bit isFilt, input int cols, input int rows, input int gapMax);
        int n;
        drive_word(isFilt, 32'(cols), 1'b0, gapMax);
        drive_word(isFilt, 32'(rows), 1'b0, gapMax);
        n = isFilt ? filtWords.size() : dataWords.size();
        for (int k = 0; k < n; k++)
            drive_word(isFilt, isFilt ? filtWords[k] : dataWords[k], k == n - 1, gapMax);
        stop_streams();
    endtask

    task automatic pulse_done();
        bus.doneIn = 1'b1;
        @(negedge clkIn);
        bus.doneIn = 1'b0;
    endtask

    task automatic apply_reset();
        stop_streams();
        bus.doneIn = 1'b0;
        rstNIn = 1'b0;
        repeat (3) @(negedge clkIn);
        rstNIn = 1'b1;
        @(negedge clkIn);
    endtask

    task automatic run_frame(input string name, input int dc, input int dr, input int fc, input int fr,
                             input int gapMax, input bit keepWords, input bit expErr, input bit doDone);
        if (!keepWords) begin
            dataWords.delete();
            filtWords.delete();
            for (int i = 0; i < dc * dr; i++) dataWords.push_back($urandom);
            for (int i = 0; i < fc * fr; i++) filtWords.push_back($urandom);
        end
        clear_mon();
        model_stream(32'd0, 1'b0);
        model_stream(32'd2048, 1'b1);
        send_stream(1'b0, dc, dr, gapMax);
        send_stream(1'b1, fc, fr, gapMax);
        for (int t = 0; t < 30 && startCnt == 0; t++) @(negedge clkIn);
        repeat (4) @(negedge clkIn);
        checks++;
        if (gotQ.size() !== expQ.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, gotQ.size(), expQ.size());
        end else begin
            foreach (expQ[i]) begin
                checks++;
                if (gotQ[i] !== expQ[i]) begin
                    errors++;
                    $display("FAIL %s write %0d: got %h expected %h", name, i, gotQ[i], expQ[i]);
                end
            end
        end
        checks++;
        if (startCnt !== 1) begin
            errors++;
            $display("FAIL %s start pulses: got %0d expected 1", name, startCnt);
        end
        if (gotQ.size() > 0) begin
            checks++;
            if (startCyc !== gotCyc[gotCyc.size()-1] + 1) begin
                errors++;
                $display("FAIL %s start timing: got cycle %0d expected %0d", name, startCyc, gotCyc[gotCyc.size()-1] + 1);
            end
        end
        checks++;
        if ({bus.dataColsOut, bus.dataRowsOut, bus.filtColsOut, bus.filtRowsOut} !== {13'(dc), 13'(dr), 13'(fc), 13'(fr)}) begin
            errors++;
            $display("FAIL %s dims: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", name, bus.dataColsOut,
                     bus.dataRowsOut, bus.filtColsOut, bus.filtRowsOut, dc, dr, fc, fr);
        end
        checks++;
        if (bus.errorOut !== expErr) begin
            errors++;
            $display("FAIL %s errorOut: got %b expected %b", name, bus.errorOut, expErr);
        end
        if (doDone) pulse_done();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.dataReadyOut, bus.filtReadyOut, bus.startOut, bus.errorOut} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: got %b expected 0000", {bus.dataReadyOut, bus.filtReadyOut, bus.startOut, bus.errorOut});
        end
        checks++;
        if ({bus.addrOut, bus.wrEnOut, bus.wrDataOut} !== 104'h0) begin
            errors++;
            $display("FAIL reset bus: got %h expected 0", {bus.addrOut, bus.wrEnOut, bus.wrDataOut});
        end
        checks++;
        if ({bus.dataColsOut, bus.dataRowsOut, bus.filtColsOut, bus.filtRowsOut} !== 52'h0) begin
            errors++;
            $display("FAIL reset dims: got %h expected 0", {bus.dataColsOut, bus.dataRowsOut, bus.filtColsOut, bus.filtRowsOut});
        end
    endtask

    task automatic test_basic_frame();
        run_frame("basic", 4, 4, 3, 3, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_valid_gaps();
        run_frame("gaps", 4, 4, 3, 3, 3, 1'b1, 1'b0, 1'b1);
        run_frame("gaps_odd", 3, 5, 2, 1, 2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_short_frame();
        clear_mon();
        dataWords.delete();
        for (int i = 0; i < 3; i++) dataWords.push_back($urandom);
        drive_word(1'b0, 32'd2, 1'b0, 0);
        drive_word(1'b0, 32'd2, 1'b0, 0);
        for (int k = 0; k < 3; k++) drive_word(1'b0, dataWords[k], k == 2, 0);
        stop_streams();
        repeat (5) @(negedge clkIn);
        checks++;
        if (gotQ.size() !== 1 || gotQ[0] !== wr_t'({32'd0, 8'hFF, dataWords[1], dataWords[0]})) begin
            errors++;
            $display("FAIL short writes: got %0d writes expected one full beat at addr 0", gotQ.size());
        end
        checks++;
        if (bus.errorOut !== 1'b1 || startCnt !== 0) begin
            errors++;
            $display("FAIL short error: got errorOut=%b starts=%0d expected 1 and 0", bus.errorOut, startCnt);
        end
        run_frame("after_short", 2, 3, 2, 2, 1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_oversize();
        apply_reset();
        checks++;
        if (bus.errorOut !== 1'b0) begin
            errors++;
            $display("FAIL oversize pre-reset errorOut: got %b expected 0", bus.errorOut);
        end
        clear_mon();
        dataWords.delete();
        for (int i = 0; i < 6; i++) dataWords.push_back($urandom);
        send_stream(1'b0, 17, 241, 1);
        repeat (5) @(negedge clkIn);
        checks++;
        if (gotQ.size() !== 0 || startCnt !== 0) begin
            errors++;
            $display("FAIL oversize writes: got %0d writes %0d starts expected 0 and 0", gotQ.size(), startCnt);
        end
        checks++;
        if ({bus.errorOut, bus.dataReadyOut, bus.filtReadyOut} !== 3'b100) begin
            errors++;
            $display("FAIL oversize state: got err/drdy/frdy=%b expected 100", {bus.errorOut, bus.dataReadyOut, bus.filtReadyOut});
        end
        apply_reset();
        run_frame("max_size", 64, 64, 1, 1, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit sawReady;
        run_frame("b2b_first", 2, 2, 2, 2, 0, 1'b0, 1'b0, 1'b0);
        bus.dataIn = 32'd3;
        bus.dataLastIn = 1'b0;
        bus.dataValidIn = 1'b1;
        sawReady = 1'b0;
        repeat (10) begin
            if (bus.dataReadyOut || bus.filtReadyOut) sawReady = 1'b1;
            @(negedge clkIn);
        end
        checks++;
        if (sawReady !== 1'b0) begin
            errors++;
            $display("FAIL wait hold-off: got ready=%b before doneIn expected 0", sawReady);
        end
        pulse_done();
        run_frame("b2b_second", 3, 2, 1, 3, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        drive_word(1'b0, 32'd4, 1'b0, 0);
        drive_word(1'b0, 32'd4, 1'b0, 0);
        for (int k = 0; k < 5; k++) drive_word(1'b0, $urandom, 1'b0, 0);
        checks++;
        if (bus.dataColsOut !== 13'd4 || bus.addrOut !== 32'd1 || bus.dataReadyOut !== 1'b1) begin
            errors++;
            $display("FAIL midframe pre-reset: got cols=%0d addr=%0d rdy=%b expected 4 1 1", bus.dataColsOut, bus.addrOut, bus.dataReadyOut);
        end
        #2 rstNIn = 1'b0;
        #1;
        checks++;
        if ({bus.dataReadyOut, bus.filtReadyOut, bus.startOut, bus.errorOut, bus.addrOut, bus.wrEnOut,
             bus.wrDataOut, bus.dataColsOut, bus.dataRowsOut} !== 134'h0) begin
            errors++;
            $display("FAIL async reset: got rdy=%b addr=%h cols=%0d rows=%0d expected all 0", bus.dataReadyOut,
                     bus.addrOut, bus.dataColsOut, bus.dataRowsOut);
        end
        stop_streams();
        @(negedge clkIn);
        rstNIn = 1'b1;
        @(negedge clkIn);
        run_frame("after_reset", 4, 4, 3, 3, 1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.dataIn = '0;
        bus.filtIn = '0;
        bus.doneIn = 1'b0;
        stop_streams();
        test_reset();
        test_basic_frame();
        test_valid_gaps();
        test_short_frame();
        test_oversize();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
